axi_read_arbiter: RTL and testbench
===================================

Name: axi_read_arbiter

Overview:
Shares the single AXI4 read-address/read-data channel pair between the fetch stage (requester 0) and the memory stage (requester 1). Accepts one cache-line burst read request at a time and grants requesters by round-robin. Drives AR, routes R beats back to the granted requester, and flags protocol/response errors. Sits between the pipeline stages and the m_axi_ar*/m_axi_r* ports of top.

Parameters:
ID_WIDTH, 13, AXI ID width
ADDR_WIDTH, 64, AXI address width
DATA_WIDTH, 64, AXI data width (bytes per beat = DATA_WIDTH/8)
BURST_LEN, 8, beats per burst; power of two, 1..256

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
req0_valid  in  1  fetch read request
req0_addr  in  ADDR_WIDTH  fetch line address
req0_ready  out  1  fetch request accepted this cycle
resp0_valid  out  1  beat valid for fetch
resp0_last  out  1  final beat for fetch
req1_valid / req1_addr / req1_ready / resp1_valid / resp1_last  same as above, for the memory stage
resp_data  out  DATA_WIDTH  beat data, shared by both requesters
err  out  1  sticky error flag
m_axi_arid  out  ID_WIDTH  zero-extended grant index
m_axi_araddr  out  ADDR_WIDTH  line-aligned address
m_axi_arlen  out  8  BURST_LEN-1
m_axi_arsize  out  3  log2(DATA_WIDTH/8), i.e. 3'b011 at default
m_axi_arburst  out  2  2'b01 (INCR)
m_axi_arlock / m_axi_arcache / m_axi_arprot  out  1/4/3  constant 0
m_axi_arvalid  out  1  address valid
m_axi_arready  in  1  address accepted
m_axi_rid  in  ID_WIDTH  read ID (ignored for routing; only one transaction is outstanding)
m_axi_rdata  in  DATA_WIDTH  read data
m_axi_rresp  in  2  read response
m_axi_rlast  in  1  last beat
m_axi_rvalid  in  1  beat valid
m_axi_rready  out  1  beat accept

Behaviour:
- Clock is clk; reset is synchronous and active-high. On reset: state=IDLE, priority pointer=0 (requester 0 favoured), beat counter=0, err=0, araddr/arid registers=0. All valid/ready/last outputs are 0 during reset and in the cycle after it.
- Three states: IDLE, ADDR, DATA.
- IDLE:
  - reqN_ready is asserted combinationally to exactly one valid requester.
  - If both requesters are valid, the pointer selects the winner. If only one is valid, it wins.
  - On accept (valid&ready in cycle T): latch the address with the low log2(BURST_LEN*DATA_WIDTH/8) bits cleared, latch the grant index, and go to ADDR. m_axi_arvalid=1 from cycle T+1.
- ADDR:
  - arvalid is held high with stable araddr, arid, and arlen until arready.
  - On arready: beat counter=0, go to DATA.
  - No reqN_ready is asserted in ADDR or DATA.
- DATA:
  - m_axi_rready=1.
  - respG_valid = m_axi_rvalid for the granted requester G only; resp_data = m_axi_rdata, combinational with zero added latency.
  - The counter increments on each accepted beat. respG_last = rvalid && counter==BURST_LEN-1.
  - Final beat (counter==BURST_LEN-1): go to IDLE and set pointer = ~G. The next request can be accepted in the cycle after the final beat.
  - Gaps in rvalid are tolerated.
- Errors:
  - err is set on any accepted beat where rresp!=2'b00, or where m_axi_rlast != (counter==BURST_LEN-1).
  - Data is still forwarded when an error occurs. Completion is always counter-based.
  - err is cleared only by reset.
- Requesters must accept beats unconditionally; there is no response backpressure.
- Reset mid-burst: returns to IDLE immediately, no resp asserted afterward. The bus is reset concurrently.
- BURST_LEN=1: every beat is last.

Decomposition:
- Package axi_pkg:
  - state enum {IDLE, ADDR, DATA}
  - AXI_BURST_INCR=2'b01
  - AXI_RESP_OKAY=2'b00
  - function for the size encoding
- Sub-module rr_arbiter2: 2-way round-robin, inputs req[1:0] and pointer, output one-hot grant. Combinational; the pointer is owned by the parent.

Test Plan:
- Single request: req0 addr 0x1000_0038 alone -> req0_ready same cycle; next cycle araddr=0x1000_0000, arlen=7, arsize=3, arburst=1, arid=0; 8 beats 0..7 -> resp0_valid×8, resp0_last on beat 7, resp1_valid never.
- Contention: both valid after reset -> req0 granted first, req1 accepted the cycle after req0's last beat with arid=1. Then both valid again -> req0 granted (pointer=0).
- arready held low 5 cycles -> arvalid and araddr stable for 6 cycles; no ready given to either requester.
- rvalid gaps (1,0,0,1,...) -> counter advances only on rvalid; last flagged on the 8th valid beat.
- rresp=2'b10 on beat 3, or rlast on beat 5 -> err=1 and stays 1; the burst still completes after 8 beats.
- Reset asserted during beat 4 -> next cycle state IDLE, no resp valid, err=0; a new req1 is accepted normally.

Source files
------------

// File: rtl/axi_pkg.sv
// axi_pkg
// Shared types and constants for the AXI4 read arbiter slice.
//   state_t   : arbiter FSM states (IDLE, ADDR, DATA)
//   AXI_BURST_INCR / AXI_RESP_OKAY : AXI encodings used by the arbiter
//   axi_size() : AxSIZE encoding (log2 of bytes per beat) for a data width
package axi_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2
    } state_t;

    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

    // AxSIZE = log2(data_width / 8); widths outside 8..1024 map to 0.
    function automatic logic [2:0] axi_size(input int data_width);
        logic [2:0] s;
        s = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if ((8 << i) == data_width) begin
                s = i[2:0];
            end
        end
        return s;
    endfunction

endpackage

// File: rtl/axi_read_arbiter_if.sv
// axi_read_arbiter_if
// AXI4 read-address (AR) and read-data (R) channel bundle.
//   master modport : the arbiter side (drives AR payload/valid, R ready)
//   slave modport  : the memory/interconnect side
//
// Handshake rule for both channels: a transfer happens on a rising clk edge
// where valid and ready are both 1. Once valid is raised the sender holds
// valid and the payload stable until that transfer; ready may be raised or
// lowered freely and never depends on the sender's future behaviour.
interface axi_read_arbiter_if #(
    parameter int ID_WIDTH   = 13,
    parameter int ADDR_WIDTH = 64,
    parameter int DATA_WIDTH = 64
);
    logic [ID_WIDTH-1:0]   arid;
    logic [ADDR_WIDTH-1:0] araddr;
    logic [7:0]            arlen;
    logic [2:0]            arsize;
    logic [1:0]            arburst;
    logic                  arlock;
    logic [3:0]            arcache;
    logic [2:0]            arprot;
    logic                  arvalid;
    logic                  arready;

    logic [ID_WIDTH-1:0]   rid;
    logic [DATA_WIDTH-1:0] rdata;
    logic [1:0]            rresp;
    logic                  rlast;
    logic                  rvalid;
    logic                  rready;

    modport master (
        output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
        input  arready,
        input  rid, rdata, rresp, rlast, rvalid,
        output rready
    );

    modport slave (
        input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
        output arready,
        output rid, rdata, rresp, rlast, rvalid,
        input  rready
    );
endinterface

// File: rtl/axi_read_arbiter_rr.sv
// rr_arbiter2
// Two-way round-robin grant logic, purely combinational.
//   req[1:0]   : request vector (bit 0 = fetch, bit 1 = memory stage)
//   pointer    : requester favoured when both request (owned by the parent)
//   grant[1:0] : one-hot grant, zero when nothing requests
module rr_arbiter2 (
    input  logic [1:0] req,
    input  logic       pointer,
    output logic [1:0] grant
);
    always_comb begin
        grant = req;
        if (req == 2'b11) begin
            grant = pointer ? 2'b10 : 2'b01;
        end
    end
endmodule

// File: rtl/axi_read_arbiter.sv
// axi_read_arbiter
// Shares one AXI4 read channel pair between the fetch stage (requester 0)
// and the memory stage (requester 1). One cache-line burst is outstanding at
// a time; requesters are served round-robin.
//   clk, reset            : clock, synchronous active-high reset
//   reqN_valid/addr/ready : line read request from requester N
//   respN_valid/last      : beat strobe / final beat for requester N
//   resp_data             : beat data shared by both requesters
//   err                   : sticky flag for bad rresp or misplaced rlast
//   dbg_state             : current FSM state
//   m_axi                 : AXI AR/R channels (master modport)
module axi_read_arbiter
    import axi_pkg::*;
#(
    parameter int ID_WIDTH   = 13,
    parameter int ADDR_WIDTH = 64,
    parameter int DATA_WIDTH = 64,
    parameter int BURST_LEN  = 8
) (
    input  logic                  clk,
    input  logic                  reset,

    input  logic                  req0_valid,
    input  logic [ADDR_WIDTH-1:0] req0_addr,
    output logic                  req0_ready,
    output logic                  resp0_valid,
    output logic                  resp0_last,

    input  logic                  req1_valid,
    input  logic [ADDR_WIDTH-1:0] req1_addr,
    output logic                  req1_ready,
    output logic                  resp1_valid,
    output logic                  resp1_last,

    output logic [DATA_WIDTH-1:0] resp_data,
    output logic                  err,
    output state_t                dbg_state,

    axi_read_arbiter_if.master    m_axi
);
    localparam int CNT_W       = ($clog2(BURST_LEN) > 0) ? $clog2(BURST_LEN) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BURST_LEN - 1);
    localparam int OFFSET_BITS = $clog2(BURST_LEN * (DATA_WIDTH / 8));
    // Clears the byte offset within one burst-sized line.
    localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = {ADDR_WIDTH{1'b1}} << OFFSET_BITS;

    state_t                state_q, state_d;
    logic                  ptr_q, ptr_d;
    logic                  gnt_q, gnt_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  err_q, err_d;
    logic [ADDR_WIDTH-1:0] araddr_q, araddr_d;
    // High only in the first cycle after reset, keeping requesters unserved.
    logic                  quiet_q;

    logic [1:0]            grant;
    logic                  beat_last;
    logic                  arvalid;
    logic                  rready;

    rr_arbiter2 u_arb (
        .req     ({req1_valid, req0_valid}),
        .pointer (ptr_q),
        .grant   (grant)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_q    <= 1'b0;
            gnt_q    <= 1'b0;
            cnt_q    <= '0;
            err_q    <= 1'b0;
            araddr_q <= '0;
            quiet_q  <= 1'b1;
        end else begin
            ptr_q    <= ptr_d;
            gnt_q    <= gnt_d;
            cnt_q    <= cnt_d;
            err_q    <= err_d;
            araddr_q <= araddr_d;
            quiet_q  <= 1'b0;
        end
    end

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        gnt_d       = gnt_q;
        cnt_d       = cnt_q;
        err_d       = err_q;
        araddr_d    = araddr_q;
        req0_ready  = 1'b0;
        req1_ready  = 1'b0;
        resp0_valid = 1'b0;
        resp1_valid = 1'b0;
        resp0_last  = 1'b0;
        resp1_last  = 1'b0;
        arvalid     = 1'b0;
        rready      = 1'b0;
        beat_last   = (cnt_q == LAST_CNT);

        // Outputs stay quiet while reset is held, whatever state_q holds.
        if (!reset) begin
            unique case (state_q)
                IDLE: begin
                    if (!quiet_q) begin
                        req0_ready = grant[0];
                        req1_ready = grant[1];
                        if (|grant) begin
                            state_d  = ADDR;
                            gnt_d    = grant[1];
                            araddr_d = (grant[1] ? req1_addr : req0_addr) & ALIGN_MASK;
                        end
                    end
                end
                ADDR: begin
                    arvalid = 1'b1;
                    if (m_axi.arready) begin
                        cnt_d   = '0;
                        state_d = DATA;
                    end
                end
                DATA: begin
                    rready      = 1'b1;
                    resp0_valid = m_axi.rvalid && !gnt_q;
                    resp1_valid = m_axi.rvalid && gnt_q;
                    resp0_last  = resp0_valid && beat_last;
                    resp1_last  = resp1_valid && beat_last;
                    if (m_axi.rvalid) begin
                        cnt_d = cnt_q + 1'b1;
                        if ((m_axi.rresp != AXI_RESP_OKAY) || (m_axi.rlast != beat_last)) begin
                            err_d = 1'b1;
                        end
                        // Completion follows the beat count, not rlast, so a
                        // bad rlast cannot stall or truncate the burst.
                        if (beat_last) begin
                            state_d = IDLE;
                            ptr_d   = ~gnt_q;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    assign m_axi.arid    = ID_WIDTH'(gnt_q);
    assign m_axi.araddr  = araddr_q;
    assign m_axi.arlen   = 8'(BURST_LEN - 1);
    assign m_axi.arsize  = axi_size(DATA_WIDTH);
    assign m_axi.arburst = AXI_BURST_INCR;
    assign m_axi.arlock  = 1'b0;
    assign m_axi.arcache = 4'd0;
    assign m_axi.arprot  = 3'd0;
    assign m_axi.arvalid = arvalid;
    assign m_axi.rready  = rready;

    assign resp_data = m_axi.rdata;
    assign err       = err_q;
    assign dbg_state = state_q;
endmodule

// File: tb/tb_axi_read_arbiter.sv
// tb_axi_read_arbiter
// Self-checking bench for axi_read_arbiter: a table of hand-computed
// transactions, a mid-burst reset sequence, and randomized transactions
// checked against a transaction-level round-robin model.
module tb_axi_read_arbiter;
    import axi_pkg::*;

    localparam int IDW = 13;
    localparam int AW  = 64;
    localparam int DW  = 64;
    localparam int BL  = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic          req0_valid, req1_valid;
    logic [AW-1:0] req0_addr, req1_addr;
    logic          req0_ready, req1_ready;
    logic          resp0_valid, resp0_last, resp1_valid, resp1_last;
    logic [DW-1:0] resp_data;
    logic          err;
    state_t        dbg_state;

    axi_read_arbiter_if #(.ID_WIDTH(IDW), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) m_axi ();

    axi_read_arbiter #(
        .ID_WIDTH(IDW), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BURST_LEN(BL)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .req0_valid  (req0_valid),
        .req0_addr   (req0_addr),
        .req0_ready  (req0_ready),
        .resp0_valid (resp0_valid),
        .resp0_last  (resp0_last),
        .req1_valid  (req1_valid),
        .req1_addr   (req1_addr),
        .req1_ready  (req1_ready),
        .resp1_valid (resp1_valid),
        .resp1_last  (resp1_last),
        .resp_data   (resp_data),
        .err         (err),
        .dbg_state   (dbg_state),
        .m_axi       (m_axi)
    );

    // ---------------- clock / watchdog ----------------
    always #5 clk = ~clk;

    initial begin
        #500_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    // ---------------- scoreboard / model ----------------
    int            checks = 0;
    int            errors = 0;
    logic [DW-1:0] exp_q[$];
    int            model_ptr;
    bit            model_err;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Round-robin rule: a lone requester wins; with two, the pointer decides.
    function automatic int model_pick(input bit v0, input bit v1);
        if (v0 && v1) return model_ptr;
        if (v0) return 0;
        if (v1) return 1;
        return -1;
    endfunction

    // ---------------- driver tasks ----------------
    // All tasks start and end 1 time unit after a rising edge; outputs are
    // sampled on the falling edge.
    task automatic apply_reset();
        reset = 1'b1;
        req0_valid = 1'b1; req1_valid = 1'b0;
        req0_addr = '0; req1_addr = '0;
        m_axi.arready = 1'b0; m_axi.rvalid = 1'b0;
        m_axi.rlast = 1'b0; m_axi.rresp = 2'b00;
        m_axi.rdata = '0; m_axi.rid = '0;
        @(negedge clk);
        check("rst_ready", {req0_ready, req1_ready}, 0);
        @(posedge clk); #1;
        reset = 1'b0;
        model_ptr = 0;
        model_err = 1'b0;
        @(negedge clk);
        check("post_rst_outs", {req0_ready, req1_ready, resp0_valid, resp1_valid,
                                resp0_last, resp1_last, m_axi.arvalid, m_axi.rready}, 0);
        check("post_rst_err", err, 0);
        check("post_rst_state", dbg_state, IDLE);
        check("post_rst_araddr", m_axi.araddr, 0);
        @(posedge clk); #1;
        req0_valid = 1'b0;
    endtask

    task automatic do_request(input bit v0, input bit v1, input logic [63:0] a0,
                              input logic [63:0] a1, input int exp_w);
        req0_valid = v0; req1_valid = v1;
        req0_addr = a0; req1_addr = a1;
        @(negedge clk);
        check("req0_ready", req0_ready, exp_w == 0);
        check("req1_ready", req1_ready, exp_w == 1);
        check("arvalid_idle", m_axi.arvalid, 0);
        check("state_idle", dbg_state, IDLE);
        check("err_idle", err, model_err);
        @(posedge clk); #1;
        if (exp_w == 0) req0_valid = 1'b0;
        else req1_valid = 1'b0;
    endtask

    task automatic do_addr(input int delay, input int exp_w, input logic [63:0] exp_addr);
        for (int k = 0; k <= delay; k++) begin
            m_axi.arready = (k == delay);
            @(negedge clk);
            check("arvalid", m_axi.arvalid, 1);
            check("araddr", m_axi.araddr, exp_addr);
            check("arid", m_axi.arid, 64'(exp_w));
            check("ar_const", {m_axi.arlen, m_axi.arsize, m_axi.arburst, m_axi.arlock,
                               m_axi.arcache, m_axi.arprot},
                  {8'd7, 3'd3, 2'd1, 1'b0, 4'd0, 3'd0});
            check("ready_in_addr", {req0_ready, req1_ready}, 0);
            @(posedge clk); #1;
        end
        m_axi.arready = 1'b0;
    endtask

    // gap_mode 0: back-to-back, 1: pattern 1,0,0,... 2: random gaps.
    // Stops after n_beats accepted beats; a full burst moves the pointer.
    task automatic do_data(input int exp_w, input int gap_mode, input int bad_resp,
                           input int bad_last, input bit rand_data, input int n_beats);
        int            b;
        int            cyc;
        bit            v;
        logic [DW-1:0] d;
        b = 0;
        cyc = 0;
        while (b < n_beats) begin
            case (gap_mode)
                0:       v = 1'b1;
                1:       v = (cyc % 3 == 0);
                default: v = (cyc > 200) ? 1'b1 : bit'($urandom_range(0, 1));
            endcase
            m_axi.rvalid = v;
            m_axi.rid = IDW'($urandom);
            d = rand_data ? {$urandom, $urandom} : DW'(b);
            m_axi.rdata = d;
            m_axi.rresp = (v && b == bad_resp) ? 2'b10 : 2'b00;
            m_axi.rlast = v && ((b == BL - 1) != (b == bad_last));
            if (v) exp_q.push_back(d);
            @(negedge clk);
            check("rready", m_axi.rready, 1);
            check("resp0_valid", resp0_valid, v && exp_w == 0);
            check("resp1_valid", resp1_valid, v && exp_w == 1);
            check("resp0_last", resp0_last, v && exp_w == 0 && b == BL - 1);
            check("resp1_last", resp1_last, v && exp_w == 1 && b == BL - 1);
            check("ready_in_data", {req0_ready, req1_ready}, 0);
            check("err_beat", err, model_err);
            if (v) check("resp_data", resp_data, exp_q.pop_front());
            @(posedge clk); #1;
            if (v) begin
                if (b == bad_resp || ((b == BL - 1) != (b == bad_last))) begin
                    if (b == bad_resp || b == bad_last) model_err = 1'b1;
                end
                b++;
            end
            cyc++;
        end
        m_axi.rvalid = 1'b0;
        m_axi.rlast = 1'b0;
        m_axi.rresp = 2'b00;
        if (n_beats == BL) model_ptr = 1 - exp_w;
    endtask

    task automatic run_txn(input bit v0, input bit v1, input logic [63:0] a0,
                           input logic [63:0] a1, input int exp_w,
                           input logic [63:0] exp_addr, input int ar_delay,
                           input int gap_mode, input int bad_resp, input int bad_last,
                           input bit rand_data);
        do_request(v0, v1, a0, a1, exp_w);
        do_addr(ar_delay, exp_w, exp_addr);
        do_data(exp_w, gap_mode, bad_resp, bad_last, rand_data, BL);
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        bit          do_reset;
        bit          v0;
        bit          v1;
        logic [63:0] a0;
        logic [63:0] a1;
        int          ar_delay;
        int          gap_mode;
        int          bad_resp;
        int          bad_last;
        int          exp_w;
        logic [63:0] exp_addr;
        bit          exp_err;
    } vec_t;

    localparam int NV = 8;
    vec_t vec[NV];

    initial begin
        bit          v0, v1;
        logic [63:0] a0, a1, ea;
        int          w, br;

        vec[0] = '{1'b1, 1'b1, 1'b0, 64'h1000_0038, 64'h0, 0, 0, -1, -1, 0, 64'h1000_0000, 1'b0};
        vec[1] = '{1'b1, 1'b1, 1'b1, 64'h2000_0040, 64'h3000_0078, 0, 0, -1, -1, 0, 64'h2000_0040, 1'b0};
        vec[2] = '{1'b0, 1'b0, 1'b1, 64'h0, 64'h3000_0078, 0, 0, -1, -1, 1, 64'h3000_0040, 1'b0};
        vec[3] = '{1'b0, 1'b1, 1'b1, 64'h4000_0100, 64'h5000_01ff, 5, 0, -1, -1, 0, 64'h4000_0100, 1'b0};
        vec[4] = '{1'b0, 1'b1, 1'b1, 64'h6000_0000, 64'h7000_00c8, 0, 1, -1, -1, 1, 64'h7000_00c0, 1'b0};
        vec[5] = '{1'b0, 1'b0, 1'b1, 64'h0, 64'h8000_0010, 2, 0, 3, -1, 1, 64'h8000_0000, 1'b1};
        vec[6] = '{1'b0, 1'b1, 1'b0, 64'h9000_0abc, 64'h0, 0, 1, -1, 5, 0, 64'h9000_0a80, 1'b1};
        vec[7] = '{1'b1, 1'b0, 1'b1, 64'h0, 64'hffff_ffff_ffff_ffff, 1, 2, -1, 7, 1,
                   64'hffff_ffff_ffff_ffc0, 1'b1};

        reset = 1'b1;
        req0_valid = 1'b0; req1_valid = 1'b0;
        req0_addr = '0; req1_addr = '0;
        m_axi.arready = 1'b0; m_axi.rvalid = 1'b0; m_axi.rlast = 1'b0;
        m_axi.rresp = 2'b00; m_axi.rdata = '0; m_axi.rid = '0;
        @(posedge clk); #1;

        // Table-driven transactions.
        for (int i = 0; i < NV; i++) begin
            if (vec[i].do_reset) apply_reset();
            run_txn(vec[i].v0, vec[i].v1, vec[i].a0, vec[i].a1, vec[i].exp_w,
                    vec[i].exp_addr, vec[i].ar_delay, vec[i].gap_mode,
                    vec[i].bad_resp, vec[i].bad_last, 1'b0);
            check("err_after_vec", err, vec[i].exp_err);
        end

        // Reset during beat 4 of a burst that already flagged an error.
        apply_reset();
        do_request(1'b1, 1'b0, 64'h1000_0000, 64'h0, 0);
        do_addr(0, 0, 64'h1000_0000);
        do_data(0, 0, 1, -1, 1'b1, 4);
        reset = 1'b1;
        m_axi.rvalid = 1'b1;
        m_axi.rdata = 64'hdead_beef;
        @(negedge clk);
        check("rst_mid_resp0", resp0_valid, 0);
        check("rst_mid_rready", m_axi.rready, 0);
        @(posedge clk); #1;
        reset = 1'b0;
        m_axi.rvalid = 1'b0;
        model_ptr = 0;
        model_err = 1'b0;
        @(negedge clk);
        check("rst_mid_state", dbg_state, IDLE);
        check("rst_mid_resp", {resp0_valid, resp1_valid, resp0_last, resp1_last}, 0);
        check("rst_mid_err", err, 0);
        check("rst_mid_arvalid", m_axi.arvalid, 0);
        @(posedge clk); #1;
        run_txn(1'b0, 1'b1, 64'h0, 64'h2222_0127, 1, 64'h2222_0100, 0, 0, -1, -1, 1'b1);

        // Randomized transactions against the round-robin model.
        apply_reset();
        for (int t = 0; t < 25; t++) begin
            v0 = bit'($urandom_range(0, 1));
            v1 = bit'($urandom_range(0, 1));
            if (!v0 && !v1) v0 = 1'b1;
            a0 = {$urandom, $urandom};
            a1 = {$urandom, $urandom};
            w = model_pick(v0, v1);
            ea = ((w == 0) ? a0 : a1) & ~64'h3f;
            br = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 7)) : -1;
            run_txn(v0, v1, a0, a1, w, ea, int'($urandom_range(0, 3)), 2, br, -1, 1'b1);
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        @(negedge clk);
        check("final_err", err, model_err);
        check("final_idle", dbg_state, IDLE);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
